// File: rtl/mem_common_pkg.sv
// Shared types for the t_mem_req / t_mem_rsp memory protocol.
// Sets the line width, the address width and the byte offset of the line index in an address.
package mem_common;

  localparam int MEM_ID_W     = 8;
  localparam int PADDR_W      = 32;
  localparam int MEM_LINE_W   = 64;
  localparam int MEM_LINE_OFS = $clog2(MEM_LINE_W / 8);

  typedef logic [MEM_ID_W-1:0]   t_mem_id;
  typedef logic [PADDR_W-1:0]    t_paddr;
  typedef logic [MEM_LINE_W-1:0] t_mem_line;

  typedef struct packed {
    logic      valid;
    t_mem_id   id;
    logic      wr;
    t_paddr    addr;
    t_mem_line data;
  } t_mem_req;

  typedef struct packed {
    logic      valid;
    t_mem_id   id;
    logic      wr;
    t_mem_line data;
  } t_mem_rsp;

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response queue with registered head and no bypass. A push and a pop may
// happen in the same cycle. A pop is ignored when the queue is empty. The caller keeps pushes out of a full queue.
module mem_rsp_fifo
  import mem_common::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  t_mem_rsp push_dat,
  input  logic     pop,
  output t_mem_rsp head,
  output logic     empty,
  output logic     full
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  t_mem_rsp      mem_q [DEPTH];
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          wr_wrap_q, wr_wrap_d;
  logic          rd_wrap_q, rd_wrap_d;
  logic          do_pop;

  assign empty  = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign full   = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign head   = mem_q[rd_idx_q];
  assign do_pop = pop && !empty;

  // Indices wrap explicitly at DEPTH-1, so the depth need not be a power of two.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (push) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (do_pop) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_wrap_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_wrap_q <= wr_wrap_d;
      rd_idx_q  <= rd_idx_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx_q] <= push_dat;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: line array, non-stalling delay pipe, credit-guarded response queue.
// A response becomes visible LATENCY cycles after its request is accepted. Responses leave in acceptance order.
module mem_responder
  import mem_common::*;
#(
  parameter int LATENCY    = 5,
  parameter int NUM_LINES  = 1024,
  parameter int RSPQ_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  t_mem_req req_nnn,
  output logic     req_ready_nnn,
  output t_mem_rsp rsp_nnn,
  input  logic     rsp_ready_nnn
);

  localparam int               IDX_W   = $clog2(NUM_LINES);
  localparam int               OCC_W   = $clog2(RSPQ_DEPTH + 1);
  localparam int               NSTG    = LATENCY - 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RSPQ_DEPTH);

  t_mem_line        mem_q [NUM_LINES];
  t_mem_rsp         pipe_q [NSTG];
  t_mem_rsp         pipe_d [NSTG];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             pop;
  t_mem_rsp         head;
  logic             q_empty;
  logic             q_full;
  logic             unused_addr;

  assign accept      = req_nnn.valid && req_ready_nnn;
  assign idx         = req_nnn.addr[MEM_LINE_OFS +: IDX_W];
  assign unused_addr = ^req_nnn.addr;
  assign pop         = rsp_nnn.valid && rsp_ready_nnn;

  // occ counts everything in the pipe and queue. Gating ready on it keeps the queue from overflowing.
  assign req_ready_nnn = reset && (occ_q < OCC_MAX);

  always_ff @(posedge clk) begin
    if (accept && req_nnn.wr) mem_q[idx] <= req_nnn.data;
  end

  always_comb begin
    pipe_d[0] = '{valid: accept,
                  id:    req_nnn.id,
                  wr:    req_nnn.wr,
                  data:  req_nnn.wr ? req_nnn.data : mem_q[idx]};
    for (int i = 1; i < NSTG; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  mem_rsp_fifo #(
    .DEPTH (RSPQ_DEPTH)
  ) u_rspq (
    .clk      (clk),
    .rst_n    (reset),
    .push     (pipe_q[NSTG-1].valid),
    .push_dat (pipe_q[NSTG-1]),
    .pop      (pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full)
  );

  always_comb begin
    rsp_nnn       = head;
    rsp_nnn.valid = head.valid && !q_empty;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
                                        !(pipe_q[NSTG-1].valid && q_full));

endmodule

// File: tb/tb_mem_responder.sv
// Directed checks on a LATENCY=5 responder plus a LATENCY=3 one for back-to-back streaming.
module tb_mem_responder;
  import mem_common::*;

  logic     clk = 1'b0;
  logic     reset;
  t_mem_req req_a, req_b;
  logic     rdy_a, rdy_b;
  t_mem_rsp rsp_a, rsp_b;
  logic     rsp_ready_a, rsp_ready_b;
  int       n_chk = 0;
  int       n_pass = 0;

  localparam t_mem_line PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(5), .NUM_LINES(1024), .RSPQ_DEPTH(4)) u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .req_nnn       (req_a),
    .req_ready_nnn (rdy_a),
    .rsp_nnn       (rsp_a),
    .rsp_ready_nnn (rsp_ready_a)
  );

  mem_responder #(.LATENCY(3), .NUM_LINES(1024), .RSPQ_DEPTH(4)) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .req_nnn       (req_b),
    .req_ready_nnn (rdy_b),
    .rsp_nnn       (rsp_b),
    .rsp_ready_nnn (rsp_ready_b)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic t_mem_req mk_req(input int id, input logic wr, input int line, input t_mem_line d);
    mk_req = '{valid: 1'b1, id: t_mem_id'(id), wr: wr,
               addr: t_paddr'(line) << MEM_LINE_OFS, data: d};
  endfunction

  function automatic t_mem_rsp mk_rsp(input int id, input logic wr, input t_mem_line d);
    mk_rsp = '{valid: 1'b1, id: t_mem_id'(id), wr: wr, data: d};
  endfunction

  task tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next response on instance A, check it, then let it pop.
  task automatic drain_a(input string tag, input int id, input logic wr, input t_mem_line d);
    int k;
    k = 0;
    while (rsp_a.valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 96'(rsp_a), 96'(mk_rsp(id, wr, d)));
    tick();
  endtask

  // Twenty requests on consecutive cycles into instance B, collected concurrently.
  task automatic stream_b(input string tag, input logic wr, input int id0);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          req_b = mk_req(id0 + i, wr, i, 64'(1000 + i));
          chk($sformatf("%s_rdy%0d", tag, i), 96'(rdy_b), 96'(1));
          tick();
        end
        req_b = '0;
      end
      begin
        int k;
        k = 0;
        while (rsp_b.valid !== 1'b1 && k < 10) begin
          tick();
          k++;
        end
        for (int j = 0; j < 20; j++) begin
          chk($sformatf("%s_rsp%0d", tag, j), 96'(rsp_b), 96'(mk_rsp(id0 + j, wr, 64'(1000 + j))));
          tick();
        end
      end
    join
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset       = 1'b0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready_a = 1'b1;
    rsp_ready_b = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 96'(rdy_a), 96'(0));
    chk("reset_vld", 96'(rsp_a.valid), 96'(0));
    #3 reset = 1'b1;
    tick();
    chk("rdy_after_reset", 96'(rdy_a), 96'(1));

    // Preload line 3, then a single read with exact-latency check.
    req_a = mk_req(1, 1'b1, 3, PAT_A5);
    tick();
    req_a = '0;
    drain_a("preload_ack", 1, 1'b1, PAT_A5);
    req_a = mk_req(2, 1'b0, 3, '0);
    tick();
    req_a = '0;
    repeat (3) tick();
    chk("rd_early", 96'(rsp_a.valid), 96'(0));
    tick();
    chk("rd_lat5", 96'(rsp_a), 96'(mk_rsp(2, 1'b0, PAT_A5)));
    tick();
    req_a = mk_req(3, 1'b0, 3 + 1024, '0);
    tick();
    req_a = '0;
    drain_a("rd_alias", 3, 1'b0, PAT_A5);

    // Write then read the same line on consecutive cycles.
    req_a = mk_req(4, 1'b1, 7, 64'h1234);
    tick();
    req_a = mk_req(5, 1'b0, 7, '0);
    tick();
    req_a = '0;
    repeat (2) tick();
    chk("wr_early", 96'(rsp_a.valid), 96'(0));
    tick();
    chk("wr_ack", 96'(rsp_a), 96'(mk_rsp(4, 1'b1, 64'h1234)));
    tick();
    chk("rd_after_wr", 96'(rsp_a), 96'(mk_rsp(5, 1'b0, 64'h1234)));
    tick();
    chk("wr_rd_idle", 96'(rsp_a.valid), 96'(0));

    // Backpressure: six back-to-back requests, only four credits.
    rsp_ready_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_a = mk_req(8 + i, 1'b1, 20 + i, 64'(100 + i));
      chk($sformatf("bp_rdy%0d", i), 96'(rdy_a), 96'(i < 4));
      tick();
    end
    req_a = '0;
    repeat (8) tick();
    chk("bp_hold_rdy", 96'(rdy_a), 96'(0));
    chk("bp_head", 96'(rsp_a), 96'(mk_rsp(8, 1'b1, 64'd100)));
    rsp_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_rsp%0d", i), 96'(rsp_a), 96'(mk_rsp(8 + i, 1'b1, 64'(100 + i))));
      tick();
    end
    chk("bp_empty", 96'(rsp_a.valid), 96'(0));
    chk("bp_rdy_back", 96'(rdy_a), 96'(1));

    // Credit corner cases around occ = 3 and occ = 4.
    rsp_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a = mk_req(40 + i, 1'b1, 30 + i, 64'(200 + i));
      tick();
    end
    req_a = '0;
    repeat (6) tick();
    chk("cr_head40", 96'(rsp_a), 96'(mk_rsp(40, 1'b1, 64'd200)));
    chk("cr_rdy_occ3", 96'(rdy_a), 96'(1));
    rsp_ready_a = 1'b1;
    req_a = mk_req(43, 1'b1, 33, 64'd203);
    tick();
    rsp_ready_a = 1'b0;
    req_a = '0;
    chk("cr_acc_pop_rdy", 96'(rdy_a), 96'(1));
    chk("cr_acc_pop_head", 96'(rsp_a), 96'(mk_rsp(41, 1'b1, 64'd201)));
    req_a = mk_req(44, 1'b1, 34, 64'd204);
    tick();
    req_a = '0;
    chk("cr_full_rdy", 96'(rdy_a), 96'(0));
    req_a = mk_req(45, 1'b1, 35, 64'd205);
    rsp_ready_a = 1'b1;
    tick();
    req_a = '0;
    rsp_ready_a = 1'b0;
    chk("cr_pop_rdy", 96'(rdy_a), 96'(1));
    chk("cr_pop_head", 96'(rsp_a), 96'(mk_rsp(42, 1'b1, 64'd202)));
    rsp_ready_a = 1'b1;
    drain_a("cr_rsp42", 42, 1'b1, 64'd202);
    drain_a("cr_rsp43", 43, 1'b1, 64'd203);
    drain_a("cr_rsp44", 44, 1'b1, 64'd204);
    seen = 0;
    repeat (10) begin
      if (rsp_a.valid === 1'b1) seen++;
      tick();
    end
    chk("cr_no_ghost", 96'(seen), 96'(0));

    // Streaming on the LATENCY=3 instance: writes fill lines 0..19, reads return them.
    stream_b("str_wr", 1'b1, 0);
    repeat (3) tick();
    stream_b("str_rd", 1'b0, 20);
    chk("str_idle", 96'(rsp_b.valid), 96'(0));

    // Reset mid-flight with responses queued and in flight.
    rsp_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a = mk_req(50 + i, 1'b0, 3, '0);
      tick();
    end
    req_a = '0;
    repeat (5) tick();
    chk("rst_pre_head", 96'(rsp_a), 96'(mk_rsp(50, 1'b0, PAT_A5)));
    #3 reset = 1'b0;
    #1;
    chk("rst_vld_async", 96'(rsp_a.valid), 96'(0));
    chk("rst_rdy_low", 96'(rdy_a), 96'(0));
    @(posedge clk);
    #4 reset = 1'b1;
    tick();
    rsp_ready_a = 1'b1;
    seen = 0;
    repeat (15) begin
      if (rsp_a.valid === 1'b1) seen++;
      tick();
    end
    chk("rst_no_stale", 96'(seen), 96'(0));
    chk("rst_rdy_after", 96'(rdy_a), 96'(1));
    req_a = mk_req(60, 1'b0, 3, '0);
    tick();
    req_a = '0;
    drain_a("rst_array_kept", 60, 1'b0, PAT_A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
